demux_route: RTL
================

// Module: demux_route
//
// PURPOSE
// - Registered 1:32 demultiplexer; inverse of the 32:1 2-bit selector. Routes
//   one 2-bit word per accepted transfer from a single input stream to one of
//   32 output channels chosen by a 5-bit select.
// - Each channel owns a one-entry holding register plus valid flag, drained by
//   a per-channel ack. Sits between a shared producer and 32 independent
//   consumers.
//
// PARAMETERS
// - DW     2   data width per channel
// - SEL_W  5   select width; NCH = 2**SEL_W = 32 channels
//
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous active-low reset
// - in_valid   in   1        producer offers in_data/in_sel this cycle
// - in_ready   out  1        block accepts the offered word this cycle
// - in_sel     in   SEL_W    destination channel index 0..31
// - in_data    in   DW       word to route
// - out_data   out  NCH*DW   packed channel regs; ch i = [DW*i+DW-1:DW*i]
// - out_valid  out  NCH      ch i holds an undelivered word
// - out_ack    in   NCH      consumer i takes its word this cycle
// - occ        out  SEL_W+1  number of channels with out_valid=1 (0..32)
//
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, out_data=0, occ=0 immediately.
//   Any word in flight or held is discarded. First acceptance is possible
//   on the first rising edge after rst_n deasserts.
// - in_ready is combinational:
//   !out_valid[in_sel] | out_ack[in_sel].
//   It does not depend on in_valid.
// - Accept = in_valid & in_ready. On that edge:
//   - out_data[ch in_sel] <= in_data
//   - out_valid[in_sel] <= 1
// - Latency: word visible on its channel exactly 1 cycle after acceptance.
// - Delivery: out_ack[i] & out_valid[i] clears out_valid[i] on that edge.
//   - out_data[i] holds its last value; it is not cleared.
//   - out_ack[i] with out_valid[i]=0 is ignored.
// - Simultaneous ack[i] and accept to ch i:
//   - the old word is delivered and the new word is loaded
//   - out_valid[i] stays 1 (full throughput, 1 word/cycle per channel)
// - Ack and accept on different channels are independent in the same cycle.
//   Any number of acks may occur per cycle.
// - Full channel (out_valid=1, no ack): in_ready=0, the word is not taken,
//   the producer holds it, and the held word is untouched. There is no
//   head-of-line bypass: a stalled word blocks all channels.
// - in_sel and in_data while in_valid=0 are don't-care; no state changes.
// - occ is registered and equals popcount(out_valid) at every edge.
//   Update rule: occ_next = occ + accept_new - delivered.
//   - accept_new = accept to a channel not being simultaneously acked-empty
//   - delivered = count of acked valid channels, excluding a reloaded one
//   Range 0..32, never wraps.
// - No X propagation: all 32 lanes are fully decoded (no default hole).
//
// TESTING
// - Reset then sweep sel=0..31 with data=sel[1:0], no acks ->
//   out_valid=32'hFFFF_FFFF, each lane i = i%4, occ=32.
// - Ch 7 full, offer sel=7 data=2'b10 with ack=0 -> in_ready=0, lane 7
//   unchanged; assert ack[7] -> in_ready=1, lane 7=2'b10 next cycle,
//   out_valid[7]=1, occ unchanged.
// - Back-to-back sel=3 every cycle with ack[3]=1 every cycle -> in_ready
//   stays 1, lane 3 updates each cycle, occ=1 steady.
// - Fill ch 0..3, ack 4'hF in one cycle -> out_valid=0, occ=0, lane data
//   retained.
// - ack[12] with out_valid[12]=0 -> no state change, occ unchanged.
// - Assert rst_n=0 mid-stream with occ=5 -> out_valid=0, out_data=0, occ=0
//   before the next clock edge; first post-reset accept is visible one cycle
//   later.

Source files
------------

// File: rtl/demux_route.sv
// Registered 1:32 demux: one 2-bit word per accepted transfer lands in a
// per-channel holding register, drained by that channel's ack.
module demux_route #(
  parameter int DW    = 2,
  parameter int SEL_W = 5,
  localparam int NCH  = 2**SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DW-1:0]     in_data,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ack,
  output logic [SEL_W:0]    occ
);

  logic             accept;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   valid_nx;
  logic [SEL_W:0]   occ_nx;

  // A full lane can still take a word if its consumer drains it this cycle.
  assign in_ready = !out_valid[in_sel] | out_ack[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    hit      = '0;
    valid_nx = '0;
    occ_nx   = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]      = accept && (in_sel == SEL_W'(i));
      valid_nx[i] = hit[i] | (out_valid[i] & ~out_ack[i]);
      occ_nx      = occ_nx + {{SEL_W{1'b0}}, valid_nx[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      occ       <= '0;
    end else begin
      out_valid <= valid_nx;
      occ       <= occ_nx;
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) out_data[DW*i +: DW] <= in_data;
      end
    end
  end

endmodule
